// File: rtl/boruss_mem_arbiter.sv
// Fixed-priority single-port memory arbiter for fetch, data and DMA requesters.
// Define BORUSS_ARB_STARVE_GUARD_EN to promote fetch/DMA after STARVE_LIMIT lost arbitrations.
module boruss_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [1:0] OWN_F    = 2'd0;
  localparam logic [1:0] OWN_D    = 2'd1;
  localparam logic [1:0] OWN_X    = 2'd2;
  localparam logic [1:0] OWN_NONE = 2'd3;

  // A latency of 0 cannot be honoured by a registered capture, so it folds to 1.
  localparam logic [3:0] LAT_LOAD = (MEM_LAT < 1) ? 4'd1 : 4'(MEM_LAT);

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              we_q, we_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        done_q, done_d;
  logic              busy_q, busy_d;

  logic              any_req;
  logic [1:0]        winner;

  assign any_req = f_req | d_req | x_req;

`ifdef BORUSS_ARB_STARVE_GUARD_EN
  localparam int              SC_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  logic [SC_W-1:0] f_starve_q, f_starve_d;
  logic [SC_W-1:0] x_starve_q, x_starve_d;

  // Promoted requesters outrank data; fetch still outranks DMA among them.
  always_comb begin
    if (f_req && (f_starve_q >= SC_MAX))      winner = OWN_F;
    else if (x_req && (x_starve_q >= SC_MAX)) winner = OWN_X;
    else if (d_req)                           winner = OWN_D;
    else if (f_req)                           winner = OWN_F;
    else                                      winner = OWN_X;
  end

  always_comb begin
    f_starve_d = f_starve_q;
    x_starve_d = x_starve_q;
    if ((state_q == S_IDLE) && any_req) begin
      if (winner == OWN_F)                   f_starve_d = '0;
      else if (f_req && f_starve_q < SC_MAX) f_starve_d = f_starve_q + SC_W'(1);
      if (winner == OWN_X)                   x_starve_d = '0;
      else if (x_req && x_starve_q < SC_MAX) x_starve_d = x_starve_q + SC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_starve_q <= '0;
      x_starve_q <= '0;
    end else begin
      f_starve_q <= f_starve_d;
      x_starve_q <= x_starve_d;
    end
  end
`else
  always_comb begin
    if (d_req)      winner = OWN_D;
    else if (f_req) winner = OWN_F;
    else            winner = OWN_X;
  end
`endif

  // Every output is a flop, so the next-cycle value of each is decided here from state_d.
  // NOTE: each variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    gnt_d       = '0;
    done_d      = '0;

    unique case (state_q)
      S_IDLE: begin
        owner_d = OWN_NONE;
        if (any_req) begin
          state_d  = S_ISSUE;
          owner_d  = winner;
          mem_en_d = 1'b1;
          unique case (winner)
            OWN_D: begin
              we_d        = d_we;
              mem_addr_d  = d_addr;
              mem_wdata_d = d_wdata;
              gnt_d[1]    = 1'b1;
            end
            OWN_F: begin
              we_d       = 1'b0;
              mem_addr_d = f_addr;
              gnt_d[0]   = 1'b1;
            end
            default: begin
              we_d        = x_we;
              mem_addr_d  = x_addr;
              mem_wdata_d = x_wdata;
              gnt_d[2]    = 1'b1;
            end
          endcase
          mem_we_d = we_d;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = LAT_LOAD;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = mem_rdata;
          unique case (owner_q)
            OWN_F:   done_d[0] = 1'b1;
            OWN_D:   done_d[1] = 1'b1;
            OWN_X:   done_d[2] = 1'b1;
            default: done_d    = '0;
          endcase
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign f_gnt     = gnt_q[0];
  assign d_gnt     = gnt_q[1];
  assign x_gnt     = gnt_q[2];
  assign f_done    = done_q[0];
  assign d_done    = done_q[1];
  assign x_done    = done_q[2];
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: doc/boruss_mem_arbiter.md
Name: boruss_mem_arbiter

Overview:
- Single-port memory arbiter shared by three requesters: instruction fetch (read-only), CPU data load/store, and a DMA/debug port.
- Sits between the CPU control FSM / load-store path and the one program/data RAM.
- Serialises accesses with fixed priority, waits a parameterised memory latency, then returns read data with a per-requester done pulse.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MEM_LAT, 1, cycles from mem_en high until mem_rdata is valid. Legal range 1..15; 0 is illegal.
- STARVE_LIMIT, 4, consecutive lost arbitrations before a requester is promoted (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- f_req  in  1  fetch request
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch accepted (1-cycle pulse)
- f_done  out  1  fetch complete, rdata valid (1-cycle pulse)
- d_req  in  1  data request
- d_we  in  1  data write enable
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- d_gnt  out  1  data accepted
- d_done  out  1  data complete
- x_req  in  1  DMA request
- x_we  in  1  DMA write enable
- x_addr  in  ADDR_W  DMA address
- x_wdata  in  DATA_W  DMA write value
- x_gnt  out  1  DMA accepted
- x_done  out  1  DMA complete
- rdata  out  DATA_W  shared read-data return
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in every state except IDLE
- owner  out  2  current owner: 0 fetch, 1 data, 2 DMA, 3 none

Behaviour:
- Reset (async): state IDLE.
  - All gnt/done low, mem_en and mem_we low.
  - mem_addr, mem_wdata and rdata = 0.
  - busy = 0, owner = 3, latency counter = 0, starvation counters = 0.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - Requests are sampled only in this state.
  - If any req is high, the winner is picked by fixed priority: data > fetch > DMA.
  - On the clock edge: latch owner, addr, we (forced 0 for fetch) and wdata; go to ISSUE.
  - No req: stay in IDLE, owner = 3.
- ISSUE (1 cycle):
  - mem_en = 1; mem_we = latched we; mem_addr/mem_wdata = latched values.
  - The owner's gnt = 1.
  - Load counter = MEM_LAT; go to WAIT.
- WAIT (MEM_LAT cycles):
  - mem_en = 0; mem_addr/mem_wdata held.
  - Counter decrements each cycle.
  - On the edge where counter == 1: if read, capture mem_rdata into rdata; go to DONE.
- DONE (1 cycle):
  - Owner's done = 1.
  - rdata valid for reads; for writes rdata holds its previous value.
  - Go to IDLE; owner returns to 3 on entering IDLE.
- Latency: req high in IDLE cycle T -> gnt at T+1 -> done at T+2+MEM_LAT.
  - Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Handshake:
  - Requester holds req/addr/we/wdata stable until it sees gnt.
  - Requester must drop req by the cycle after gnt unless it wants another access.
  - A req still high when the arbiter returns to IDLE is a new request.
- Losing requesters receive no gnt and keep waiting; no request is dropped.
- Simultaneous requests: one winner per IDLE cycle; the others are served on later IDLE cycles in priority order.
- Reset mid-operation: the access is abandoned, no done is issued, mem_en is forced low immediately.
- mem_en is never high for two consecutive cycles.
- Illegal MEM_LAT (0): behaves as 1.

Optional Feature:
- Macro: BORUSS_ARB_STARVE_GUARD_EN.
- Defined:
  - Fetch and DMA each keep a saturating lost-arbitration counter.
  - The counter increments in an IDLE cycle where that requester's req is high and it loses.
  - The counter clears when that requester is granted.
  - When a counter reaches STARVE_LIMIT, that requester beats data priority. If both fetch and DMA are promoted, fetch wins.
- Undefined: pure fixed priority; counters absent.

Test Plan:
- Single fetch, MEM_LAT=1, f_addr=0x10, mem returns 0xA5 -> f_gnt 1 cycle after req, mem_en/mem_addr=0x10 for one cycle, f_done 3 cycles after req, rdata=0xA5, mem_we=0.
- Data write, d_addr=0x20, d_wdata=0x3C, MEM_LAT=3 -> mem_en=1/mem_we=1/mem_wdata=0x3C for exactly one cycle, d_done 5 cycles after req, rdata unchanged.
- f_req, d_req, x_req asserted together, each holding until its gnt -> grant order data, fetch, DMA; each done precedes the next gnt; owner goes 1,3,0,3,2,3.
- Reset asserted in WAIT -> next cycle busy=0, owner=3, no done pulse; a new f_req after reset completes normally.
- With BORUSS_ARB_STARVE_GUARD_EN, STARVE_LIMIT=4, d_req held continuously and f_req high -> f_gnt on the 5th arbitration; without the macro, fetch is never granted while d_req stays high.
- MEM_LAT=0 build -> timing identical to the MEM_LAT=1 scenario.
